// File: rtl/wb_dshot_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : wb_dshot_tx                                                    |
// | Purpose : Wishbone B4 classic slave that turns throttle writes into      |
// |           DSHOT frames (12-bit value + 4-bit CRC, MSB first), one        |
// |           independent serial line per ESC channel.                       |
// | Ports   : i_clk, i_rst      - clock, synchronous active-high reset       |
// |           s_wb_*            - Wishbone slave (adr[5:2] decoded)          |
// |           o_dshot[NUM_CH]   - DSHOT lines, idle low                      |
// | Map     : W0..7 channel value, W8 STATUS (RO), W9 CONFIG, others err     |
// | Option  : DSHOT_REPEAT_EN - CONFIG holds per-channel auto-repeat enables |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module wb_dshot_tx #(
  parameter int CLK_FREQ_HZ = 48000000,
  parameter int DSHOT_KBPS  = 600,
  parameter int NUM_CH      = 4,
  parameter int GUARD_BITS  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       s_wb_adr_i,
  input  logic [31:0]       s_wb_dat_i,
  output logic [31:0]       s_wb_dat_o,
  input  logic              s_wb_we_i,
  input  logic [3:0]        s_wb_sel_i,
  input  logic              s_wb_stb_i,
  input  logic              s_wb_cyc_i,
  output logic              s_wb_ack_o,
  output logic              s_wb_err_o,
  output logic [NUM_CH-1:0] o_dshot
);

  localparam int T          = CLK_FREQ_HZ / (DSHOT_KBPS * 1000);
  localparam int T1H        = (3 * T) / 4;
  localparam int T0H        = (3 * T) / 8;
  localparam int GUARD_CLKS = GUARD_BITS * T;
  localparam int MAX_CLKS   = (GUARD_CLKS > T) ? GUARD_CLKS : T;
  localparam int CW         = $clog2(MAX_CLKS + 1);

  localparam logic [CW-1:0] C_T1H   = CW'(T1H);
  localparam logic [CW-1:0] C_T0H   = CW'(T0H);
  localparam logic [CW-1:0] C_T1L   = CW'(T - T1H);
  localparam logic [CW-1:0] C_T0L   = CW'(T - T0H);
  localparam logic [CW-1:0] C_GUARD = CW'(GUARD_CLKS);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [3:0]    C_NCH   = 4'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GUARD  = 2'd3
  } state_t;

  function automatic logic [15:0] make_frame(input logic [11:0] v);
    return {v, v[3:0] ^ v[7:4] ^ v[11:8]};
  endfunction

  // ---------------- bus decode ----------------
  logic        req, is_ch, ch_ok, sel_ok, bad, ch_wr;
  logic [3:0]  widx;
  logic [11:0] wdat;
  logic [31:0] rdata;

  logic [NUM_CH-1:0] busy, pend, cfg;
  logic [11:0]       chv [NUM_CH];

  // A new request is only seen while no response is being driven, which
  // yields single-cycle responses and a dead cycle between transfers.
  assign req    = s_wb_stb_i & s_wb_cyc_i & ~(s_wb_ack_o | s_wb_err_o);
  assign widx   = s_wb_adr_i[5:2];
  assign is_ch  = ~widx[3];
  assign ch_ok  = is_ch & (widx < C_NCH);
  assign sel_ok = (s_wb_sel_i[1:0] == 2'b11);
  assign bad    = is_ch ? (~ch_ok | (s_wb_we_i & ~sel_ok)) : (widx >= 4'd10);
  assign ch_wr  = req & ~bad & s_wb_we_i & is_ch;
  assign wdat   = s_wb_dat_i[11:0];

  always_comb begin
    rdata = '0;
    if (is_ch) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (widx[2:0] == 3'(n)) begin
          rdata[11:0] = chv[n];
          rdata[30]   = pend[n];
          rdata[31]   = busy[n];
        end
      end
    end else if (widx == 4'd8) begin
      rdata[NUM_CH-1:0]   = busy;
      rdata[NUM_CH+7:8]   = pend;
    end else if (widx == 4'd9) begin
      rdata[NUM_CH-1:0]   = cfg;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_wb_ack_o <= 1'b0;
      s_wb_err_o <= 1'b0;
      s_wb_dat_o <= '0;
    end else begin
      s_wb_ack_o <= req & ~bad;
      s_wb_err_o <= req & bad;
      s_wb_dat_o <= (req & ~bad & ~s_wb_we_i) ? rdata : '0;
    end
  end

`ifdef DSHOT_REPEAT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg <= '0;
    end else if (req & ~bad & s_wb_we_i & (widx == 4'd9)) begin
      cfg <= s_wb_dat_i[NUM_CH-1:0];
    end
  end
`else
  assign cfg = '0;
`endif

  logic unused;
  assign unused = &{1'b0, s_wb_adr_i[31:6], s_wb_adr_i[1:0], s_wb_dat_i[31:12],
                    s_wb_sel_i[3:2]};

  // ---------------- per-channel serialisers ----------------
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t        st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   sh, sh_n, fr;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [11:0]   val, ldv;
    logic          pnd, pnd_n, load, dout, wr, last;

    assign wr   = ch_wr & (widx[2:0] == 3'(n));
    assign last = (cnt == C_ONE);

    always_comb begin
      st_n      = st;
      cnt_n     = cnt;
      sh_n      = sh;
      bit_idx_n = bit_idx;
      pnd_n     = pnd | wr;
      load      = 1'b0;
      ldv       = val;      // pending slot always equals the last written value
      case (st)
        IDLE: begin
          if (wr) begin
            load = 1'b1;
            ldv  = wdat;
          end
        end
        BIT_HI: begin
          if (last) begin
            st_n  = BIT_LO;
            cnt_n = sh[15] ? C_T1L : C_T0L;
          end else begin
            cnt_n = cnt - C_ONE;
          end
        end
        BIT_LO: begin
          if (last) begin
            if (bit_idx == 4'd15) begin
              st_n  = GUARD;
              cnt_n = C_GUARD;
            end else begin
              st_n      = BIT_HI;
              sh_n      = {sh[14:0], 1'b0};
              bit_idx_n = bit_idx + 4'd1;
              cnt_n     = sh[14] ? C_T1H : C_T0H;
            end
          end else begin
            cnt_n = cnt - C_ONE;
          end
        end
        GUARD: begin
          if (last) begin
            // A write landing on the final guard cycle goes straight out,
            // taking precedence over an older pending value.
            if (wr) begin
              load = 1'b1;
              ldv  = wdat;
            end else if (pnd | cfg[n]) begin
              load = 1'b1;
            end else begin
              st_n = IDLE;
            end
          end else begin
            cnt_n = cnt - C_ONE;
          end
        end
        default: st_n = IDLE;
      endcase
      fr = make_frame(ldv);
      if (load) begin
        st_n      = BIT_HI;
        sh_n      = fr;
        bit_idx_n = 4'd0;
        cnt_n     = fr[15] ? C_T1H : C_T0H;
        pnd_n     = 1'b0;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        st      <= IDLE;
        cnt     <= '0;
        sh      <= '0;
        bit_idx <= '0;
        val     <= '0;
        pnd     <= 1'b0;
        dout    <= 1'b0;
      end else begin
        st      <= st_n;
        cnt     <= cnt_n;
        sh      <= sh_n;
        bit_idx <= bit_idx_n;
        pnd     <= pnd_n;
        // Line lags the state by one cycle so it rises the cycle after ack.
        dout    <= (st == BIT_HI);
        if (wr) val <= wdat;
      end
    end

    assign busy[n]    = (st != IDLE);
    assign pend[n]    = pnd;
    assign chv[n]     = val;
    assign o_dshot[n] = dout;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_dshot_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_wb_dshot_tx                                                 |
// | Purpose : Self-checking bench for wb_dshot_tx. A waveform-level model    |
// |           (frame value + position in the frame) predicts every output    |
// |           each cycle; directed sections pin absolute timings.            |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_wb_dshot_tx;
  localparam int CLK_FREQ_HZ = 48000000;
  localparam int DSHOT_KBPS  = 600;
  localparam int NUM_CH      = 4;
  localparam int GUARD_BITS  = 2;
  localparam int T     = CLK_FREQ_HZ / (DSHOT_KBPS * 1000);
  localparam int T1H   = (3 * T) / 4;
  localparam int T0H   = (3 * T) / 8;
  localparam int FRAME = 16 * T;
  localparam int TOTAL = FRAME + GUARD_BITS * T;

  logic clk = 1'b0;
  logic rst, we, stb, cyc, ack, err;
  logic [31:0] adr, dat_i, dat_o;
  logic [3:0]  sel;
  logic [NUM_CH-1:0] dshot;

  always #5 clk = ~clk;

  wb_dshot_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .DSHOT_KBPS(DSHOT_KBPS),
    .NUM_CH(NUM_CH), .GUARD_BITS(GUARD_BITS)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .s_wb_adr_i(adr), .s_wb_dat_i(dat_i), .s_wb_dat_o(dat_o),
    .s_wb_we_i(we), .s_wb_sel_i(sel), .s_wb_stb_i(stb), .s_wb_cyc_i(cyc),
    .s_wb_ack_o(ack), .s_wb_err_o(err), .o_dshot(dshot)
  );

  // ---------------- model state ----------------
  int                pos   [NUM_CH];   // position in frame+guard, TOTAL = idle
  logic [15:0]       fr    [NUM_CH];
  bit                pend  [NUM_CH];
  logic [11:0]       chm   [NUM_CH];
  logic [NUM_CH-1:0] cfg_m;
  logic [NUM_CH-1:0] eo;
  bit                eack, eerr, erd;
  logic [31:0]       edat;

  int vec = 0, bad_n = 0, cyc_n = 0, t_req = 0;
  int hi_cnt [NUM_CH];
  int rise_cyc [NUM_CH];
  logic [NUM_CH-1:0] prev_o = '0;
  bit samp [1450];

  function automatic logic [15:0] dframe(input int v);
    int c;
    c = (v ^ (v >> 4) ^ (v >> 8)) & 'hF;
    return 16'((v << 4) | c);
  endfunction

  function automatic bit wave(input logic [15:0] f, input int p);
    int b;
    if (p >= FRAME) return 1'b0;
    b = 15 - p / T;
    return (p % T) < (f[b] ? T1H : T0H);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      pos[n] = TOTAL; fr[n] = '0; pend[n] = 0; chm[n] = '0;
    end
    cfg_m = '0; eo = '0; eack = 0; eerr = 0; erd = 0; edat = '0;
  endtask

  task automatic model_step();
    bit req, isch, chok, bad, wrn, bz;
    int w;
    logic [31:0] rdv;
    logic [NUM_CH-1:0] neo;
    logic [11:0] v;
    w    = int'(adr[5:2]);
    v    = dat_i[11:0];
    req  = stb && cyc && !(eack || eerr);
    isch = (w < 8);
    chok = (w < NUM_CH);
    bad  = isch ? (!chok || (we && sel[1:0] != 2'b11)) : (w >= 10);
    rdv  = '0;
    if (isch && chok) begin
      rdv[11:0] = chm[w]; rdv[30] = pend[w]; rdv[31] = (pos[w] < TOTAL);
    end else if (w == 8) begin
      for (int n = 0; n < NUM_CH; n++) begin
        rdv[n] = (pos[n] < TOTAL); rdv[8+n] = pend[n];
      end
    end else if (w == 9) begin
      rdv[NUM_CH-1:0] = cfg_m;
    end
    neo = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      bz = (pos[n] < TOTAL);
      neo[n] = bz && wave(fr[n], pos[n]);
      if (bz) pos[n]++;
      wrn = req && !bad && we && isch && (w == n);
      if (pos[n] >= TOTAL) begin
        if (wrn) begin fr[n] = dframe(int'(v)); pos[n] = 0; pend[n] = 0; end
        else if (pend[n]) begin fr[n] = dframe(int'(chm[n])); pos[n] = 0; pend[n] = 0; end
        else if (cfg_m[n]) begin fr[n] = dframe(int'(chm[n])); pos[n] = 0; end
      end else if (wrn) begin
        pend[n] = 1;
      end
      if (wrn) chm[n] = v;
    end
`ifdef DSHOT_REPEAT_EN
    if (req && !bad && we && w == 9) cfg_m = dat_i[NUM_CH-1:0];
`endif
    if (rst) model_reset();
    else begin
      eo = neo; eack = req && !bad; eerr = req && bad; erd = !we; edat = rdv;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    cmp("dshot", 32'(dshot), 32'(eo));
    cmp("ack", 32'(ack), 32'(eack));
    cmp("err", 32'(err), 32'(eerr));
    if (eack && erd) cmp("rdata", dat_o, edat);
    for (int n = 0; n < NUM_CH; n++) begin
      hi_cnt[n] += int'(dshot[n]);
      if (dshot[n] && !prev_o[n]) rise_cyc[n] = cyc_n;
    end
    prev_o = dshot;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wb(input bit w_e, input int w, input logic [31:0] d, input logic [3:0] s,
                    output bit ga, output bit ge, output logic [31:0] rd);
    if (eack || eerr) step();
    stb = 1; cyc = 1; we = w_e; sel = s; dat_i = d;
    adr = ($urandom() & ~32'h3C) | (32'(w) << 2);
    t_req = cyc_n;
    step();
    ga = ack; ge = err; rd = dat_o;
    stb = 0; cyc = 0; we = 0;
  endtask

  function automatic int ones(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(samp[i]);
    return s;
  endfunction

  task automatic clr_hi();
    for (int n = 0; n < NUM_CH; n++) hi_cnt[n] = 0;
  endtask

  initial begin
    bit ga, ge;
    logic [31:0] rd;
    int t1, nack;
    model_reset();
    clr_hi();
    for (int n = 0; n < NUM_CH; n++) rise_cyc[n] = 0;
    rst = 1; we = 0; stb = 0; cyc = 0; sel = 4'hF; adr = '0; dat_i = '0;

    // Reset state
    idle(3);
    rst = 0;
    step();
    cmp("rst_dshot", 32'(dshot), 32'd0);
    wb(0, 8, 0, 4'hF, ga, ge, rd);
    cmp("rst_status_ack", 32'(ga), 32'd1);
    cmp("rst_status", rd, 32'd0);

    // Single frame 0x82C -> 0x82C6
    wb(1, 0, 32'h0000_082C, 4'hF, ga, ge, rd);
    t1 = t_req;
    cmp("w0_ack", 32'(ga), 32'd1);
    cmp("pre_rise", 32'(dshot[0]), 32'd0);
    for (int i = 0; i < 1450; i++) begin step(); samp[i] = dshot[0]; end
    cmp("rise_2cyc", 32'(samp[0]), 32'd1);
    cmp("bit15_hi60", 32'(ones(0, 79)), 32'd60);
    cmp("bit14_hi30", 32'(ones(80, 159)), 32'd30);
    cmp("frame_hi", 32'(ones(0, 1279)), 32'd660);
    cmp("guard_lo", 32'(ones(1280, 1449)), 32'd0);
    wb(0, 8, 0, 4'hF, ga, ge, rd);
    cmp("busy_dropped", rd, 32'd0);

    // Pending / last write wins
    clr_hi();
    wb(1, 1, 32'h100, 4'hF, ga, ge, rd);
    idle(300);
    wb(1, 1, 32'h200, 4'hF, ga, ge, rd);
    wb(0, 8, 0, 4'hF, ga, ge, rd);
    cmp("status9_pend", 32'(rd[9]), 32'd1);
    idle(200);
    wb(1, 1, 32'h300, 4'hF, ga, ge, rd);
    idle(3500);
    cmp("two_frames_hi", 32'(hi_cnt[1]), 32'd1140);

    // Errors
    clr_hi();
    wb(1, 5, 32'h123, 4'hF, ga, ge, rd);
    cmp("w5_err", 32'(ge), 32'd1);
    cmp("w5_noack", 32'(ga), 32'd0);
    wb(1, 0, 32'h456, 4'b0001, ga, ge, rd);
    cmp("sel_err", 32'(ge), 32'd1);
    wb(0, 12, 0, 4'hF, ga, ge, rd);
    cmp("r12_err", 32'(ge), 32'd1);
    wb(1, 8, 32'hFFFF, 4'hF, ga, ge, rd);
    cmp("status_wr_ack", 32'(ga), 32'd1);
    idle(20);
    cmp("err_no_out", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'd0);
    wb(0, 0, 0, 4'hF, ga, ge, rd);
    cmp("ch0_kept", rd, 32'h0000_082C);

    // Reset in bit 7 of a frame
    wb(1, 2, 32'hABC, 4'hF, ga, ge, rd);
    idle(1 + 7 * T + 10);
    rst = 1;
    step();
    cmp("rst_mid_low", 32'(dshot), 32'd0);
    rst = 0;
    clr_hi();
    idle(2000);
    cmp("rst_no_resume", 32'(hi_cnt[2]), 32'd0);
    wb(0, 8, 0, 4'hF, ga, ge, rd);
    cmp("rst_status0", rd, 32'd0);

    // Write landing in the final guard cycle
    wb(1, 3, 32'h82C, 4'hF, ga, ge, rd);
    t1 = t_req;
    while (cyc_n < t1 + TOTAL) step();
    wb(1, 3, 32'h555, 4'hF, ga, ge, rd);
    idle(5);
    cmp("no_gap_rise", 32'(rise_cyc[3] - t1), 32'(TOTAL + 2));
    idle(TOTAL + 10);

    // Back-to-back reads with strobe held
    if (eack || eerr) step();
    stb = 1; cyc = 1; we = 0; sel = 4'hF; adr = 32'h20;
    nack = 0;
    for (int i = 0; i < 12; i++) begin step(); nack += int'(ack); end
    stb = 0; cyc = 0;
    cmp("b2b_acks", 32'(nack), 32'd6);
    step();

`ifdef DSHOT_REPEAT_EN
    wb(1, 9, 32'h1, 4'hF, ga, ge, rd);
    wb(1, 0, 32'h0, 4'hF, ga, ge, rd);
    t1 = t_req;
    clr_hi();
    while (cyc_n < t1 + 1 + 3 * TOTAL) step();
    cmp("repeat_hi", 32'(hi_cnt[0]), 32'(3 * 16 * T0H));
    cmp("repeat_rise", 32'(rise_cyc[0] - t1), 32'(2 + 2 * TOTAL + 15 * T));
    wb(1, 9, 32'h0, 4'hF, ga, ge, rd);
    idle(2 * TOTAL);
    wb(0, 8, 0, 4'hF, ga, ge, rd);
    cmp("repeat_stopped", rd, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        wb(1, $urandom_range(0, 7), $urandom(),
           ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF, ga, ge, rd);
      end else if (r < 62) begin
        wb(1, 9, $urandom(), 4'hF, ga, ge, rd);
      end else if (r < 70) begin
        wb(1, $urandom_range(8, 15), $urandom(), 4'hF, ga, ge, rd);
      end else begin
        wb(0, $urandom_range(0, 15), 0, 4'($urandom_range(0, 15)), ga, ge, rd);
      end
      idle($urandom_range(0, 150));
    end
    wb(1, 9, 32'h0, 4'hF, ga, ge, rd);
    idle(2 * TOTAL + 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad_n);
    $finish;
  end
endmodule
`default_nettype wire
